ped_xing_scheduler: RTL and testbench

- Pedestrian crossing scheduler that sits beside TLC_FSM.
- Latches crossing requests for road A and road B and arbitrates between them round-robin.
- Asks TLC_FSM to hold the served road red, then sequences WALK, FLASH (don't-walk) and CLEAR phases with a countdown for the display.
- Also detects a light conflict during a crossing.

---
 rtl/ped_xing_scheduler.sv | 145 ++++++++++++++
 tb/tb_ped_xing_scheduler.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ped_xing_scheduler.sv
// Pedestrian crossing scheduler: latches A/B requests, arbitrates round-robin, holds the served road red and runs WALK/FLASH/CLEAR.
// Latency: a request reaches WAIT_RED two edges later; it waits for red indefinitely. Outputs decode from registered state only.
module ped_xing_scheduler #(
  parameter int         WALK_CYC  = 4,
  parameter int         FLASH_CYC = 2,
  parameter int         CLEAR_CYC = 1,
  parameter logic [1:0] RED       = 2'b10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ped_req_a,
  input  logic       ped_req_b,
  input  logic [1:0] rA,
  input  logic [1:0] rB,
  output logic       hold_a,
  output logic       hold_b,
  output logic       pend_a,
  output logic       pend_b,
  output logic       walk_a,
  output logic       walk_b,
  output logic       flash_a,
  output logic       flash_b,
  output logic [7:0] timer_display,
  output logic       err_conflict
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_WAIT_RED = 3'd1;
  localparam logic [2:0] S_WALK     = 3'd2;
  localparam logic [2:0] S_FLASH    = 3'd3;
  localparam logic [2:0] S_CLEAR    = 3'd4;

  localparam logic [7:0] WALK_LD  = 8'(WALK_CYC - 1);
  localparam logic [7:0] FLASH_LD = 8'(FLASH_CYC - 1);
  localparam logic [7:0] CLEAR_LD = 8'(CLEAR_CYC - 1);

  logic [2:0] state;
  logic [7:0] cnt;
  logic       sel;          // 0 = crossing A, 1 = crossing B
  logic       last_served;
  logic       sel_red;
  logic       enter_walk;

  assign sel_red    = sel ? (rB == RED) : (rA == RED);
  assign enter_walk = (state == S_WAIT_RED) && sel_red;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= S_IDLE;
      cnt          <= 8'd0;
      sel          <= 1'b0;
      last_served  <= 1'b1;
      pend_a       <= 1'b0;
      pend_b       <= 1'b0;
      err_conflict <= 1'b0;
    end else begin
      // Clearing on WALK entry wins over a same-edge request; WALK of x ignores x.
      if (enter_walk && !sel)
        pend_a <= 1'b0;
      else if (ped_req_a && !((state == S_WALK) && !sel))
        pend_a <= 1'b1;

      if (enter_walk && sel)
        pend_b <= 1'b0;
      else if (ped_req_b && !((state == S_WALK) && sel))
        pend_b <= 1'b1;

      case (state)
        S_IDLE: begin
          if (pend_a || pend_b) begin
            sel   <= (pend_a && pend_b) ? ~last_served : pend_b;
            state <= S_WAIT_RED;
          end
        end
        S_WAIT_RED: begin
          if (sel_red) begin
            state <= S_WALK;
            cnt   <= WALK_LD;
          end
        end
        S_WALK: begin
          if (!sel_red) begin
            err_conflict <= 1'b1;
            state        <= S_CLEAR;
            cnt          <= CLEAR_LD;
          end else if (cnt == 8'd0) begin
            state <= S_FLASH;
            cnt   <= FLASH_LD;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        S_FLASH: begin
          if (!sel_red) begin
            err_conflict <= 1'b1;
            state        <= S_CLEAR;
            cnt          <= CLEAR_LD;
          end else if (cnt == 8'd0) begin
            state <= S_CLEAR;
            cnt   <= CLEAR_LD;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        S_CLEAR: begin
          if (cnt == 8'd0) begin
            state       <= S_IDLE;
            last_served <= sel;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        default: begin
          state <= S_IDLE;
          cnt   <= 8'd0;
        end
      endcase
    end
  end

  always_comb begin
    hold_a        = 1'b0;
    hold_b        = 1'b0;
    walk_a        = 1'b0;
    walk_b        = 1'b0;
    flash_a       = 1'b0;
    flash_b       = 1'b0;
    timer_display = 8'd0;
    if (state != S_IDLE) begin
      hold_a = !sel;
      hold_b = sel;
    end
    if (state == S_WALK) begin
      walk_a = !sel;
      walk_b = sel;
    end
    if (state == S_FLASH) begin
      flash_a = !sel;
      flash_b = sel;
    end
    if ((state == S_WALK) || (state == S_FLASH) || (state == S_CLEAR))
      timer_display = cnt + 8'd1;
  end

endmodule

// File: tb/tb_ped_xing_scheduler.sv
// Directed bench for ped_xing_scheduler with hand-computed per-cycle output vectors.
module tb_ped_xing_scheduler;

  localparam logic [1:0] RED_C   = 2'b10;
  localparam logic [1:0] GREEN_C = 2'b00;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       ped_req_a = 1'b0;
  logic       ped_req_b = 1'b0;
  logic [1:0] rA = RED_C;
  logic [1:0] rB = RED_C;
  logic       hold_a, hold_b, pend_a, pend_b;
  logic       walk_a, walk_b, flash_a, flash_b;
  logic [7:0] timer_display;
  logic       err_conflict;

  int total = 0;
  int bad   = 0;

  // {hold_a,hold_b,pend_a,pend_b, walk_a,walk_b,flash_a,flash_b, err_conflict, timer_display}
  logic [16:0] obs;
  assign obs = {hold_a, hold_b, pend_a, pend_b, walk_a, walk_b, flash_a, flash_b,
                err_conflict, timer_display};

  ped_xing_scheduler dut (
    .clk           (clk),
    .rst           (rst),
    .ped_req_a     (ped_req_a),
    .ped_req_b     (ped_req_b),
    .rA            (rA),
    .rB            (rB),
    .hold_a        (hold_a),
    .hold_b        (hold_b),
    .pend_a        (pend_a),
    .pend_b        (pend_b),
    .walk_a        (walk_a),
    .walk_b        (walk_b),
    .flash_a       (flash_a),
    .flash_b       (flash_b),
    .timer_display (timer_display),
    .err_conflict  (err_conflict)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Expected vector for step k (0..6) of a service: 4 WALK, 2 FLASH, 1 CLEAR.
  function automatic logic [16:0] svc(input logic b, input int k, input logic other_pend,
                                      input logic err);
    logic [3:0] hp;
    logic [3:0] wf;
    logic [7:0] t;
    hp = b ? 4'b0100 : 4'b1000;
    if (other_pend) hp = hp | (b ? 4'b0010 : 4'b0001);
    if (k < 4) begin
      wf = b ? 4'b0100 : 4'b1000;
      t  = 8'(4 - k);
    end else if (k < 6) begin
      wf = b ? 4'b0001 : 4'b0010;
      t  = 8'(6 - k);
    end else begin
      wf = 4'b0000;
      t  = 8'd1;
    end
    return {hp, wf, err, t};
  endfunction

  task automatic test_reset;
    for (int i = 0; i < 3; i++) begin
      #3;
      ped_req_a = ~ped_req_a;
      ped_req_b = ped_req_a;
    end
    #2;
    total++;
    if (obs !== 17'h0) begin
      bad++;
      $display("FAIL reset_hold obs=%h exp=%h", obs, 17'h0);
    end
    #1;
    ped_req_a = 1'b0;
    ped_req_b = 1'b0;
    rst       = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if (obs !== 17'h0) begin
        bad++;
        $display("FAIL reset_idle[%0d] obs=%h exp=%h", i, obs, 17'h0);
      end
    end
  endtask

  task automatic test_single_a;
    logic [16:0] exp;
    ped_req_a = 1'b1;
    tick();
    ped_req_a = 1'b0;
    exp = {4'b0010, 4'b0000, 1'b0, 8'd0};
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL single_a_pend obs=%h exp=%h", obs, exp);
    end
    tick();
    exp = {4'b1010, 4'b0000, 1'b0, 8'd0};
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL single_a_wait obs=%h exp=%h", obs, exp);
    end
    for (int k = 0; k < 7; k++) begin
      tick();
      exp = svc(1'b0, k, 1'b0, 1'b0);
      total++;
      if (obs !== exp) begin
        bad++;
        $display("FAIL single_a_step[%0d] obs=%h exp=%h", k, obs, exp);
      end
    end
    tick();
    total++;
    if (obs !== 17'h0) begin
      bad++;
      $display("FAIL single_a_idle obs=%h exp=%h", obs, 17'h0);
    end
  endtask

  task automatic test_wait_red;
    logic [16:0] exp;
    rB        = GREEN_C;
    ped_req_b = 1'b1;
    tick();
    ped_req_b = 1'b0;
    exp = {4'b0001, 4'b0000, 1'b0, 8'd0};
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL wait_red_pend obs=%h exp=%h", obs, exp);
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      exp = {4'b0101, 4'b0000, 1'b0, 8'd0};
      total++;
      if (obs !== exp) begin
        bad++;
        $display("FAIL wait_red_hold[%0d] obs=%h exp=%h", i, obs, exp);
      end
    end
    rB = RED_C;
    for (int k = 0; k < 7; k++) begin
      tick();
      exp = svc(1'b1, k, 1'b0, 1'b0);
      total++;
      if (obs !== exp) begin
        bad++;
        $display("FAIL wait_red_step[%0d] obs=%h exp=%h", k, obs, exp);
      end
    end
    tick();
    total++;
    if (obs !== 17'h0) begin
      bad++;
      $display("FAIL wait_red_idle obs=%h exp=%h", obs, 17'h0);
    end
  endtask

  task automatic test_tie_fairness;
    logic [16:0] exp;
    for (int r = 0; r < 2; r++) begin
      ped_req_a = 1'b1;
      ped_req_b = 1'b1;
      tick();
      ped_req_a = 1'b0;
      ped_req_b = 1'b0;
      exp = {4'b0011, 4'b0000, 1'b0, 8'd0};
      total++;
      if (obs !== exp) begin
        bad++;
        $display("FAIL tie%0d_pend obs=%h exp=%h", r, obs, exp);
      end
      tick();
      exp = {4'b1011, 4'b0000, 1'b0, 8'd0};
      total++;
      if (obs !== exp) begin
        bad++;
        $display("FAIL tie%0d_a_first obs=%h exp=%h", r, obs, exp);
      end
      for (int k = 0; k < 7; k++) begin
        tick();
        exp = svc(1'b0, k, 1'b1, 1'b0);
        total++;
        if (obs !== exp) begin
          bad++;
          $display("FAIL tie%0d_a_step[%0d] obs=%h exp=%h", r, k, obs, exp);
        end
      end
      tick();
      exp = {4'b0001, 4'b0000, 1'b0, 8'd0};
      total++;
      if (obs !== exp) begin
        bad++;
        $display("FAIL tie%0d_idle_b_pend obs=%h exp=%h", r, obs, exp);
      end
      tick();
      exp = {4'b0101, 4'b0000, 1'b0, 8'd0};
      total++;
      if (obs !== exp) begin
        bad++;
        $display("FAIL tie%0d_b_wait obs=%h exp=%h", r, obs, exp);
      end
      for (int k = 0; k < 7; k++) begin
        tick();
        exp = svc(1'b1, k, 1'b0, 1'b0);
        total++;
        if (obs !== exp) begin
          bad++;
          $display("FAIL tie%0d_b_step[%0d] obs=%h exp=%h", r, k, obs, exp);
        end
      end
      tick();
      total++;
      if (obs !== 17'h0) begin
        bad++;
        $display("FAIL tie%0d_idle obs=%h exp=%h", r, obs, 17'h0);
      end
    end
  endtask

  task automatic test_conflict;
    logic [16:0] exp;
    ped_req_a = 1'b1;
    tick();
    ped_req_a = 1'b0;
    tick();
    exp = {4'b1010, 4'b0000, 1'b0, 8'd0};
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL conflict_wait obs=%h exp=%h", obs, exp);
    end
    for (int k = 0; k < 2; k++) begin
      tick();
      exp = svc(1'b0, k, 1'b0, 1'b0);
      total++;
      if (obs !== exp) begin
        bad++;
        $display("FAIL conflict_walk[%0d] obs=%h exp=%h", k, obs, exp);
      end
    end
    rA = GREEN_C;
    tick();
    exp = {4'b1000, 4'b0000, 1'b1, 8'd1};
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL conflict_clear obs=%h exp=%h", obs, exp);
    end
    rA = RED_C;
    for (int i = 0; i < 3; i++) begin
      tick();
      exp = {4'b0000, 4'b0000, 1'b1, 8'd0};
      total++;
      if (obs !== exp) begin
        bad++;
        $display("FAIL conflict_sticky[%0d] obs=%h exp=%h", i, obs, exp);
      end
    end
  endtask

  task automatic test_midop_reset;
    logic [16:0] exp;
    ped_req_a = 1'b1;
    tick();
    ped_req_a = 1'b0;
    tick();
    for (int k = 0; k < 5; k++) tick();
    exp = svc(1'b0, 4, 1'b0, 1'b1);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL midop_flash obs=%h exp=%h", obs, exp);
    end
    #1;
    rst = 1'b0;
    #1;
    total++;
    if (obs !== 17'h0) begin
      bad++;
      $display("FAIL midop_async_clear obs=%h exp=%h", obs, 17'h0);
    end
    #1;
    rst = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      total++;
      if (obs !== 17'h0) begin
        bad++;
        $display("FAIL midop_no_service[%0d] obs=%h exp=%h", i, obs, 17'h0);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_a();
    test_wait_red();
    test_tie_fairness();
    test_conflict();
    test_midop_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
